// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and helpers for the serial adder controller.
// Holds the state encoding and the index-width sizing rule.
`timescale 1ns/1ps
package serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_P1   = 2'd1,
    S_P2   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // A one-bit adder still needs a one-bit index, so clamp at 1.
  function automatic int idxWidth(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_halfadder.sv
// Single-bit half adder shared by both passes of the serial adder.
`timescale 1ns/1ps
module halfadder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Multi-cycle unsigned adder that reuses one half adder twice per bit:
// pass 1 forms a^b / a&b, pass 2 folds in the running carry.
`timescale 1ns/1ps
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int IdxW = idxWidth(WIDTH);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] opA_q;
  logic [WIDTH-1:0] opB_q;
  logic [IdxW-1:0]  idx_q;
  logic             carry_q;
  logic             s1_q;
  logic             c1_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  logic haA_d;
  logic haB_d;
  logic haSum;
  logic haCarry;

  // Input mux for the shared half adder; parked at zero outside P1/P2.
  always_comb begin
    haA_d = 1'b0;
    haB_d = 1'b0;
    case (state_q)
      S_P1: begin
        haA_d = opA_q[idx_q];
        haB_d = opB_q[idx_q];
      end
      S_P2: begin
        haA_d = s1_q;
        haB_d = carry_q;
      end
      default: ;
    endcase
  end

  halfadder u_halfadder (
    .a     (haA_d),
    .b     (haB_d),
    .sum   (haSum),
    .carry (haCarry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      opA_q   <= '0;
      opB_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      s1_q    <= 1'b0;
      c1_q    <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            opA_q   <= a;
            opB_q   <= b;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_P1;
          end
        end
        S_P1: begin
          s1_q    <= haSum;
          c1_q    <= haCarry;
          state_q <= S_P2;
        end
        S_P2: begin
          sum_q[idx_q] <= haSum;
          carry_q      <= c1_q | haCarry;
          // The two half-adder carries can never both be set, so OR is exact.
          if (idx_q == LastIdx) begin
            cout_q  <= c1_q | haCarry;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q   <= idx_q + IdxW'(1);
            state_q <= S_P1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
